// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if
//   Bundles the pipeline-side signals of the hazard controller.
//   master : the pipeline datapath. It drives the ID/EX/MEM status and
//            receives the hold/flush controls, the status and the counters.
//   slave  : the hazard controller itself (pipeline_hazard_ctrl).
//   Inputs to controller : id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd,
//                          ex_reg_write, ex_is_load, ex_branch_taken,
//                          ex_md_start, md_done, mem_wait
//   Outputs from ctrl    : pc_hold, ifid_hold, idex_hold, exmem_hold,
//                          ifid_flush, idex_flush, exmem_flush, memwb_flush,
//                          busy_state, md_timeout, stall_cnt, flush_cnt
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_is_load;
  logic        ex_branch_taken;
  logic        ex_md_start;
  logic        md_done;
  logic        mem_wait;

  logic        pc_hold;
  logic        ifid_hold;
  logic        idex_hold;
  logic        exmem_hold;
  logic        ifid_flush;
  logic        idex_flush;
  logic        exmem_flush;
  logic        memwb_flush;
  logic        busy_state;
  logic        md_timeout;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write,
           ex_is_load, ex_branch_taken, ex_md_start, md_done, mem_wait,
    input  pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
           exmem_flush, memwb_flush, busy_state, md_timeout, stall_cnt,
           flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_reg_write,
           ex_is_load, ex_branch_taken, ex_md_start, md_done, mem_wait,
    output pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush,
           exmem_flush, memwb_flush, busy_state, md_timeout, stall_cnt,
           flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Stall/flush controller for a 5-stage pipeline: load-use interlock,
//   taken-branch flush, data-memory wait freeze and a multi-cycle mul/div
//   busy state with a 64-cycle watchdog. Also keeps saturating stall and
//   branch-flush performance counters.
//   Ports:
//     clk  - clock, all state updates on the rising edge
//     rst  - synchronous, active-high reset
//     bus  - pipeline_hazard_ctrl_if.slave (hazard inputs, hold/flush
//            controls, busy_state, md_timeout, stall_cnt, flush_cnt)
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   ST_RUN     | normal issue; hazards resolved by priority each cycle
//   ST_MD_BUSY | mul/div in EX; front end held until md_done or timeout
module pipeline_hazard_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MD_BUSY = 1'b1
  } state_t;

  localparam logic [5:0]  MD_TIMER_MAX = 6'd63;
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [5:0]  r_md_timer;
  logic [5:0]  w_md_timer_nxt;
  logic        r_md_timeout;
  logic        w_md_timeout_nxt;
  logic [15:0] r_stall_cnt;
  logic [15:0] r_flush_cnt;

  logic        w_rs1_hit;
  logic        w_rs2_hit;
  logic        w_load_use;

  logic        w_pc_hold;
  logic        w_ifid_hold;
  logic        w_idex_hold;
  logic        w_exmem_hold;
  logic        w_ifid_flush;
  logic        w_idex_flush;
  logic        w_exmem_flush;
  logic        w_memwb_flush;
  logic        w_branch_flush;

  // x0 is hardwired zero, so a load targeting it can never feed ID.
  assign w_rs1_hit  = bus.id_use_rs1 && (bus.id_rs1 == bus.ex_rd);
  assign w_rs2_hit  = bus.id_use_rs2 && (bus.id_rs2 == bus.ex_rd);
  assign w_load_use = bus.ex_is_load && bus.ex_reg_write &&
                      (bus.ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

  always_comb begin
    w_state_nxt      = r_state;
    w_md_timer_nxt   = r_md_timer;
    w_md_timeout_nxt = r_md_timeout;
    w_pc_hold        = 1'b0;
    w_ifid_hold      = 1'b0;
    w_idex_hold      = 1'b0;
    w_exmem_hold     = 1'b0;
    w_ifid_flush     = 1'b0;
    w_idex_flush     = 1'b0;
    w_exmem_flush    = 1'b0;
    w_memwb_flush    = 1'b0;
    w_branch_flush   = 1'b0;

    if (rst) begin
      w_state_nxt      = ST_RUN;
      w_md_timer_nxt   = 6'd0;
      w_md_timeout_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (bus.mem_wait) begin
            // Whole pipe up to EX/MEM freezes; MEM/WB gets a bubble so the
            // stalled access is not written back twice.
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_hold   = 1'b1;
            w_exmem_hold  = 1'b1;
            w_memwb_flush = 1'b1;
          end else if (bus.ex_branch_taken) begin
            // Wrong-path instructions in IF/ID and ID/EX are squashed; any
            // load-use or mul/div start from the squashed path is moot.
            w_ifid_flush   = 1'b1;
            w_idex_flush   = 1'b1;
            w_branch_flush = 1'b1;
          end else if (bus.ex_md_start) begin
            w_pc_hold      = 1'b1;
            w_ifid_hold    = 1'b1;
            w_idex_hold    = 1'b1;
            w_exmem_flush  = 1'b1;
            w_state_nxt    = ST_MD_BUSY;
            w_md_timer_nxt = 6'd0;
          end else if (w_load_use) begin
            // One bubble suffices: next cycle the load is in MEM and the
            // value is forwardable.
            w_pc_hold    = 1'b1;
            w_ifid_hold  = 1'b1;
            w_idex_flush = 1'b1;
          end
        end

        ST_MD_BUSY: begin
          if (bus.mem_wait) begin
            // Freeze takes precedence; md_done stays high until accepted,
            // so ignoring it here loses nothing.
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_hold   = 1'b1;
            w_exmem_hold  = 1'b1;
            w_memwb_flush = 1'b1;
          end else if (bus.md_done) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_pc_hold     = 1'b1;
            w_ifid_hold   = 1'b1;
            w_idex_hold   = 1'b1;
            w_exmem_flush = 1'b1;
            if (r_md_timer == MD_TIMER_MAX) begin
              w_md_timeout_nxt = 1'b1;
              w_state_nxt      = ST_RUN;
            end else begin
              w_md_timer_nxt = r_md_timer + 6'd1;
            end
          end
        end

        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_state      <= w_state_nxt;
    r_md_timer   <= w_md_timer_nxt;
    r_md_timeout <= w_md_timeout_nxt;
    if (rst) begin
      r_stall_cnt <= 16'd0;
      r_flush_cnt <= 16'd0;
    end else begin
      if (w_pc_hold && (r_stall_cnt != CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 16'd1;
      end
      if (w_branch_flush && (r_flush_cnt != CNT_MAX)) begin
        r_flush_cnt <= r_flush_cnt + 16'd1;
      end
    end
  end

  assign bus.pc_hold     = w_pc_hold;
  assign bus.ifid_hold   = w_ifid_hold;
  assign bus.idex_hold   = w_idex_hold;
  assign bus.exmem_hold  = w_exmem_hold;
  assign bus.ifid_flush  = w_ifid_flush;
  assign bus.idex_flush  = w_idex_flush;
  assign bus.exmem_flush = w_exmem_flush;
  assign bus.memwb_flush = w_memwb_flush;
  // Reported idle while rst is high, even before the state register clears.
  assign bus.busy_state  = (r_state == ST_MD_BUSY) && !rst;
  assign bus.md_timeout  = r_md_timeout;
  assign bus.stall_cnt   = r_stall_cnt;
  assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (hz.slave)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic [4:0] rd;
    logic       rw;
    logic       ld;
    logic       br;
    logic       mds;
    logic       mdd;
    logic       mw;
  } in_t;

  // hf = {pc_hold, ifid_hold, idex_hold, exmem_hold,
  //       ifid_flush, idex_flush, exmem_flush, memwb_flush}
  typedef struct packed {
    logic [7:0]  hf;
    logic        busy;
    logic        tmo;
    logic [15:0] sc;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    in_t        v;
    logic [7:0] hf;
    logic       busy;
  } step_t;

  localparam logic [7:0] HF_NONE = 8'h00;
  localparam logic [7:0] HF_MEMW = 8'hF1;
  localparam logic [7:0] HF_BR   = 8'h0C;
  localparam logic [7:0] HF_MD   = 8'hE2;
  localparam logic [7:0] HF_LU   = 8'hC4;

  obs_t        q_exp[$];
  step_t       steps[$];
  logic [15:0] exp_sc;
  logic [15:0] exp_fc;
  logic        exp_tmo;
  int          n_checks;
  int          n_fail;
  obs_t        got;
  obs_t        want;

  function automatic in_t f_idle();
    in_t v;
    v = '0;
    return v;
  endfunction

  function automatic in_t f_load(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic use1, input logic [4:0] rs2,
                                 input logic use2);
    in_t v;
    v      = '0;
    v.ld   = 1'b1;
    v.rw   = 1'b1;
    v.rd   = rd;
    v.rs1  = rs1;
    v.use1 = use1;
    v.rs2  = rs2;
    v.use2 = use2;
    return v;
  endfunction

  function automatic obs_t sample();
    return obs_t'({hz.pc_hold, hz.ifid_hold, hz.idex_hold, hz.exmem_hold,
                   hz.ifid_flush, hz.idex_flush, hz.exmem_flush, hz.memwb_flush,
                   hz.busy_state, hz.md_timeout, hz.stall_cnt, hz.flush_cnt});
  endfunction

  task automatic apply(input in_t v);
    rst                = v.rst;
    hz.id_rs1          = v.rs1;
    hz.id_rs2          = v.rs2;
    hz.id_use_rs1      = v.use1;
    hz.id_use_rs2      = v.use2;
    hz.ex_rd           = v.rd;
    hz.ex_reg_write    = v.rw;
    hz.ex_is_load      = v.ld;
    hz.ex_branch_taken = v.br;
    hz.ex_md_start     = v.mds;
    hz.md_done         = v.mdd;
    hz.mem_wait        = v.mw;
  endtask

  // Drives one cycle of stimulus and queues what the DUT must show in it.
  // Counters are registered, so the queued values are those accumulated
  // before this cycle; the model then advances them for the next one.
  task automatic drive(input in_t v, input logic [7:0] hf, input logic busy);
    apply(v);
    q_exp.push_back(obs_t'({hf, busy, exp_tmo, exp_sc, exp_fc}));
    if (v.rst) begin
      exp_sc  = 16'd0;
      exp_fc  = 16'd0;
      exp_tmo = 1'b0;
    end else begin
      if (hf[7] && exp_sc != 16'hFFFF) exp_sc = exp_sc + 16'd1;
      if (hf == HF_BR && exp_fc != 16'hFFFF) exp_fc = exp_fc + 16'd1;
    end
  endtask

  task automatic add(input in_t v, input logic [7:0] hf, input logic busy);
    step_t s;
    s.v    = v;
    s.hf   = hf;
    s.busy = busy;
    steps.push_back(s);
  endtask

  task automatic test_reset();
    in_t v;
    v     = f_load(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    v.br  = 1'b1;
    v.mds = 1'b1;
    v.mw  = 1'b1;
    v.rst = 1'b1;
    apply(v);
    @(posedge clk); #1;
    exp_sc  = 16'd0;
    exp_fc  = 16'd0;
    exp_tmo = 1'b0;
    steps.delete();
    add(v, HF_NONE, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL reset step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_use();
    in_t v;
    steps.delete();
    add(f_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1), HF_LU, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    add(f_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1), HF_NONE, 1'b0);
    add(f_load(5'd7, 5'd7, 1'b0, 5'd3, 1'b1), HF_NONE, 1'b0);
    add(f_load(5'd7, 5'd7, 1'b1, 5'd3, 1'b0), HF_LU, 1'b0);
    v = f_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); v.ld = 1'b0;
    add(v, HF_NONE, 1'b0);
    v = f_load(5'd7, 5'd7, 1'b1, 5'd0, 1'b0); v.rw = 1'b0;
    add(v, HF_NONE, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL load_use step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_priority();
    in_t v;
    steps.delete();
    v = f_load(5'd5, 5'd0, 1'b0, 5'd5, 1'b1); v.br = 1'b1;
    add(v, HF_BR, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    v = f_idle(); v.br = 1'b1; v.mds = 1'b1;
    add(v, HF_BR, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    v = f_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); v.br = 1'b1; v.mds = 1'b1; v.mw = 1'b1;
    add(v, HF_MEMW, 1'b0);
    v = f_idle(); v.mw = 1'b1;
    add(v, HF_MEMW, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    v = f_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); v.mds = 1'b1;
    add(v, HF_MD, 1'b0);
    v = f_idle(); v.mdd = 1'b1;
    add(v, HF_NONE, 1'b1);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL branch_priority step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_normal();
    in_t v;
    steps.delete();
    v = f_idle(); v.mds = 1'b1;
    add(v, HF_MD, 1'b0);
    for (int k = 0; k < 4; k++) add(f_idle(), HF_MD, 1'b1);
    v = f_idle(); v.mdd = 1'b1;
    add(v, HF_NONE, 1'b1);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL md_normal step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_md_memwait();
    in_t v;
    steps.delete();
    v = f_idle(); v.mds = 1'b1;
    add(v, HF_MD, 1'b0);
    add(f_idle(), HF_MD, 1'b1);
    add(f_idle(), HF_MD, 1'b1);
    v = f_idle(); v.mw = 1'b1; v.mdd = 1'b1;
    for (int k = 0; k < 3; k++) add(v, HF_MEMW, 1'b1);
    v = f_idle(); v.mdd = 1'b1;
    add(v, HF_NONE, 1'b1);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL md_memwait step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  // 64 counting MD_BUSY cycles with a 3-cycle mem_wait in the middle; the
  // timeout must land on the 64th counting cycle, not 3 cycles earlier.
  task automatic test_md_timeout();
    in_t        v;
    logic [7:0] hf;
    logic       b;
    for (int k = 0; k < 72; k++) begin
      v  = f_idle();
      hf = HF_MD;
      b  = 1'b1;
      if (k == 0) begin
        v.mds = 1'b1; b = 1'b0;
      end else if (k >= 31 && k <= 33) begin
        v.mw = 1'b1; hf = HF_MEMW;
      end else if (k == 68) begin
        hf = HF_NONE; b = 1'b0;
      end else if (k == 69) begin
        v.mds = 1'b1; b = 1'b0;
      end else if (k == 70) begin
        v.mdd = 1'b1; hf = HF_NONE;
      end else if (k == 71) begin
        hf = HF_NONE; b = 1'b0;
      end
      drive(v, hf, b);
      if (k == 67) exp_tmo = 1'b1;
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL md_timeout cycle %0d: observed %h, expected %h", k, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rst_mid_busy();
    in_t v;
    steps.delete();
    v = f_idle(); v.mds = 1'b1;
    add(v, HF_MD, 1'b0);
    add(f_idle(), HF_MD, 1'b1);
    v = f_idle(); v.rst = 1'b1; v.mw = 1'b1;
    add(v, HF_NONE, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rst_mid_busy step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_saturation();
    in_t lu;
    test_reset();
    lu = f_load(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    apply(lu);
    repeat (65534) @(posedge clk);
    #1;
    exp_sc = 16'hFFFE;
    steps.delete();
    add(lu, HF_LU, 1'b0);
    add(lu, HF_LU, 1'b0);
    add(lu, HF_LU, 1'b0);
    add(lu, HF_LU, 1'b0);
    add(lu, HF_LU, 1'b0);
    add(lu, HF_LU, 1'b0);
    add(f_idle(), HF_NONE, 1'b0);
    foreach (steps[i]) begin
      drive(steps[i].v, steps[i].hf, steps[i].busy);
      @(negedge clk);
      got  = sample();
      want = q_exp.pop_front();
      n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL saturation step %0d: observed %h, expected %h", i, got, want);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_sc   = 16'd0;
    exp_fc   = 16'd0;
    exp_tmo  = 1'b0;
    apply(f_idle());
    rst = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_load_use();
    test_branch_priority();
    test_md_normal();
    test_md_memwait();
    test_md_timeout();
    test_rst_mid_busy();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: observed simulation still running at time limit, expected finish");
    $fatal(1, "time limit reached");
  end

endmodule
